cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) among NUM_FU functional-unit result ports in the out-of-order core.
- Each cycle it picks one valid requester round-robin and accepts its packet (tag + data) with a valid/ready handshake.
- It registers the packet onto the CDB one cycle later for ROB/reservation-station wakeup.
- A pipeline flush discards everything in flight.

Parameters:
- NUM_FU, 4, number of requesting functional units (>=2).
- XLEN, 32, result data width.
- ROB_W, 5, ROB tag width.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous active-high reset
- req_valid  in  NUM_FU  per-FU result valid
- req_tag  in  NUM_FU x ROB_W  per-FU destination ROB tag
- req_data  in  NUM_FU x XLEN  per-FU result data
- req_ready  out  NUM_FU  per-FU grant/accept (one-hot or zero)
- flush  in  1  squash all in-flight results
- cdb_valid  out  1  CDB broadcast valid
- cdb_tag  out  ROB_W  broadcast ROB tag
- cdb_data  out  XLEN  broadcast data
- cdb_src  out  $clog2(NUM_FU)  index of the granted FU
- stat_grants  out  32  grant counter (see Optional Feature)
- stat_conflicts  out  32  conflict-cycle counter (see Optional Feature)

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset: cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, rr_ptr=0, stats=0. req_ready is 0 while reset=1.
- req_ready is combinational from req_valid, rr_ptr and flush.
  - At most one bit is set, and only for a requester with req_valid=1.
- Transfer: occurs at a clk edge where req_valid[i] & req_ready[i].
- FU rules:
  - An FU holds valid/tag/data stable until it sees ready.
  - A non-granted FU keeps requesting and is never dropped.
- Selection:
  - Scan indices rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_FU.
  - The first index with valid wins.
  - After a transfer from i, rr_ptr <= (i+1) mod NUM_FU.
  - With no transfer, rr_ptr holds.
- Latency: a transfer at edge t makes cdb_valid=1 with that tag/data/src for exactly the cycle following edge t.
  - One packet per cycle sustained; no back-pressure from the CDB side.
- No transfer at edge t: cdb_valid=0 after t. tag/data/src hold their last values (don't-care when invalid).
- Fairness: any continuously-valid FU is granted within NUM_FU cycles.
- Flush: while flush=1, req_ready=0 (no transfer) and cdb_valid<=0 at the next edge.
  - A packet already on the CDB in the flush cycle is still visible that cycle; consumers qualify it with flush.
  - rr_ptr holds.
- Simultaneous reset and flush: reset wins.
- reset asserted mid-stream: no transfer; all state returns to reset values at that edge.

Optional Feature:
- Macro: CDB_STATS_EN.
- Defined:
  - stat_grants increments on every transfer edge.
  - stat_conflicts increments on every edge where two or more req_valid bits are set and flush=0.
  - Both counters are 32-bit, saturate at 0xFFFF_FFFF, and clear on reset.
- Undefined: counter logic is omitted. stat_grants and stat_conflicts are tied to 0 (ports always exist).

Decomposition:
- Package cdb_pkg:
  - NUM_FU, XLEN, ROB_W defaults.
  - FU_IDX_W = $clog2(NUM_FU).
  - Typedef cdb_pkt_t {valid, tag, data, src}.
  - Typedef fu_idx_t.
- Sub-module rr_pick: purely combinational rotate-priority encoder.
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, index, any.
- cdb_arbiter owns the rr_ptr register, the output register, flush gating and the stats.

Test Plan:
- Single requester: NUM_FU=4, only FU2 valid with tag=5, data=0xDEADBEEF.
  -> req_ready=0100 in the same cycle.
  -> Next cycle cdb_valid=1, cdb_tag=5, cdb_data=0xDEADBEEF, cdb_src=2; rr_ptr=3.
- All four FUs continuously valid from reset.
  -> Grants in order 0,1,2,3,0 on consecutive cycles; cdb_valid stays 1 every cycle.
  -> With CDB_STATS_EN: stat_conflicts=5, stat_grants=5 after 5 cycles.
- Wrap-around: rr_ptr=3, FU0 and FU3 valid -> FU3 granted first, FU0 next cycle, rr_ptr=1.
- Hold under contention: FU1 (tag=7) and FU2 valid with rr_ptr=2 -> FU1 req_ready=0 and its tag stays 7; FU1 granted the following cycle.
- Flush: FU0 valid on the same cycle flush=1.
  -> req_ready=0000; cdb_valid=0 next cycle; rr_ptr unchanged.
  -> FU0 granted the first cycle after flush deasserts.
- Reset mid-stream: reset=1 while cdb_valid=1 and rr_ptr=2.
  -> Next cycle cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, rr_ptr=0, stats=0.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared widths, index type and CDB packet layout for the CDB arbiter slice.
// The package constants are the single configuration point for FU count and widths.
package cdb_pkg;

    localparam int NUM_FU   = 4;
    localparam int XLEN     = 32;
    localparam int ROB_W    = 5;
    localparam int FU_IDX_W = $clog2(NUM_FU);

    typedef logic [FU_IDX_W-1:0] fu_idx_t;

    typedef struct packed {
        logic             valid;
        logic [ROB_W-1:0] tag;
        logic [XLEN-1:0]  data;
        fu_idx_t          src;
    } cdb_pkt_t;

    // Round-robin successor, wrapping at NUM_FU (which need not be a power of two).
    function automatic fu_idx_t next_idx(input fu_idx_t i);
        return (int'(i) == NUM_FU - 1) ? '0 : fu_idx_t'(i + 1'b1);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: first set request at or after i_ptr wins.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_grant,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    int w_j;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = 0;
        // Walk from the farthest offset back to the pointer so the nearest hit is written last.
        for (int k = N - 1; k >= 0; k--) begin
            w_j = (int'(i_ptr) + k) % N;
            if (i_req[w_j]) begin
                o_grant      = '0;
                o_grant[w_j] = 1'b1;
                o_idx        = W'(w_j);
                o_any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the common data bus among the FU result ports.
// Optional statistics counters are built only when CDB_STATS_EN is defined.
module cdb_arbiter
    import cdb_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_FU-1:0]        req_valid,
    input  logic [NUM_FU*ROB_W-1:0]  req_tag,
    input  logic [NUM_FU*XLEN-1:0]   req_data,
    output logic [NUM_FU-1:0]        req_ready,
    input  logic                     flush,
    output logic                     cdb_valid,
    output logic [ROB_W-1:0]         cdb_tag,
    output logic [XLEN-1:0]          cdb_data,
    output logic [FU_IDX_W-1:0]      cdb_src,
    output logic [31:0]              stat_grants,
    output logic [31:0]              stat_conflicts
);

    fu_idx_t             r_rr_ptr;
    cdb_pkt_t            r_pkt;
    logic [NUM_FU-1:0]   w_grant;
    fu_idx_t             w_idx;
    logic                w_any;
    logic                w_xfer;

    rr_pick #(
        .N (NUM_FU),
        .W (FU_IDX_W)
    ) u_pick (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Flush and reset both suppress the grant, so no FU believes it was accepted.
    assign req_ready = (reset || flush) ? '0 : w_grant;
    assign w_xfer    = w_any && !flush && !reset;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            r_pkt    <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_pkt.valid <= w_xfer;
            if (w_xfer) begin
                r_pkt.tag  <= req_tag[w_idx*ROB_W +: ROB_W];
                r_pkt.data <= req_data[w_idx*XLEN +: XLEN];
                r_pkt.src  <= w_idx;
                r_rr_ptr   <= next_idx(w_idx);
            end
        end
    end

    assign cdb_valid = r_pkt.valid;
    assign cdb_tag   = r_pkt.tag;
    assign cdb_data  = r_pkt.data;
    assign cdb_src   = r_pkt.src;

`ifdef CDB_STATS_EN
    logic [31:0] r_stat_grants;
    logic [31:0] r_stat_conflicts;
    logic        w_conflict;

    assign w_conflict = ($countones(req_valid) >= 2) && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_grants    <= '0;
            r_stat_conflicts <= '0;
        end else begin
            if (w_xfer)     r_stat_grants    <= sat_inc(r_stat_grants);
            if (w_conflict) r_stat_conflicts <= sat_inc(r_stat_conflicts);
        end
    end

    assign stat_grants    = r_stat_grants;
    assign stat_conflicts = r_stat_conflicts;
`else
    assign stat_grants    = '0;
    assign stat_conflicts = '0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: stimulus pushes expected CDB packets, a negedge monitor pops them.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_FU-1:0]       req_valid;
    logic [NUM_FU*ROB_W-1:0] req_tag;
    logic [NUM_FU*XLEN-1:0]  req_data;
    logic [NUM_FU-1:0]       req_ready;
    logic                    flush;
    logic                    cdb_valid;
    logic [ROB_W-1:0]        cdb_tag;
    logic [XLEN-1:0]         cdb_data;
    logic [FU_IDX_W-1:0]     cdb_src;
    logic [31:0]             stat_grants;
    logic [31:0]             stat_conflicts;

    typedef struct {
        logic [ROB_W-1:0]    tag;
        logic [XLEN-1:0]     data;
        logic [FU_IDX_W-1:0] src;
    } exp_t;

    exp_t             exp_q[$];
    logic [ROB_W-1:0] fu_tag[NUM_FU];
    logic [XLEN-1:0]  fu_data[NUM_FU];
    int               total = 0;
    int               bad   = 0;

    cdb_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_tag        (req_tag),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .flush          (flush),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_data       (cdb_data),
        .cdb_src        (cdb_src),
        .stat_grants    (stat_grants),
        .stat_conflicts (stat_conflicts)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every valid CDB cycle must match the oldest expected packet.
    always @(negedge clk) begin
        if (cdb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("cdb_unexpected", 64'(cdb_valid), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("cdb_tag",  64'(cdb_tag),  64'(e.tag));
                check("cdb_data", 64'(cdb_data), 64'(e.data));
                check("cdb_src",  64'(cdb_src),  64'(e.src));
            end
        end
    end

    task automatic drive(input logic [NUM_FU-1:0] v, input logic fl);
        for (int i = 0; i < NUM_FU; i++) begin
            req_tag[i*ROB_W +: ROB_W] = fu_tag[i];
            req_data[i*XLEN +: XLEN]  = fu_data[i];
        end
        req_valid = v;
        flush     = fl;
        #1;
    endtask

    // Compare req_ready against the hand-computed grant and queue the packet it implies.
    task automatic expect_grant(input string name, input logic [NUM_FU-1:0] exp_ready);
        exp_t e;
        check(name, 64'(req_ready), 64'(exp_ready));
        for (int i = 0; i < NUM_FU; i++) begin
            if (exp_ready[i]) begin
                e.tag  = fu_tag[i];
                e.data = fu_data[i];
                e.src  = FU_IDX_W'(i);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state();
        check("rst_cdb_valid", 64'(cdb_valid), 64'd0);
        check("rst_cdb_tag",   64'(cdb_tag),   64'd0);
        check("rst_cdb_data",  64'(cdb_data),  64'd0);
        check("rst_cdb_src",   64'(cdb_src),   64'd0);
        check("rst_grants",    64'(stat_grants),    64'd0);
        check("rst_conflicts", 64'(stat_conflicts), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < NUM_FU; i++) begin
            fu_tag[i]  = '0;
            fu_data[i] = '0;
        end
        reset = 1'b1;
        drive(4'b1111, 1'b0);
        check("ready_in_reset", 64'(req_ready), 64'd0);
        tick();
        check_reset_state();
        reset = 1'b0;
        drive(4'b0000, 1'b0);
        tick();
        check("idle_valid", 64'(cdb_valid), 64'd0);

        // Single requester FU2; rr_ptr becomes 3.
        fu_tag[2] = 5'd5; fu_data[2] = 32'hDEAD_BEEF;
        drive(4'b0100, 1'b0);
        expect_grant("single_ready", 4'b0100);
        tick();
        check("single_valid", 64'(cdb_valid), 64'd1);
        drive(4'b0000, 1'b0);
        tick();
        check("single_idle", 64'(cdb_valid), 64'd0);

        // Wrap-around from rr_ptr=3: FU3 first, then FU0; rr_ptr becomes 1.
        fu_tag[0] = 5'd1; fu_data[0] = 32'hA0A0_0000;
        fu_tag[3] = 5'd3; fu_data[3] = 32'h3333_3333;
        drive(4'b1001, 1'b0);
        expect_grant("wrap_ready0", 4'b1000);
        tick();
        drive(4'b0001, 1'b0);
        expect_grant("wrap_ready1", 4'b0001);
        tick();

        // Move rr_ptr to 2, then contention: FU2 wins, FU1 holds tag 7 and wins next.
        fu_tag[1] = 5'd9; fu_data[1] = 32'h1111_0000;
        drive(4'b0010, 1'b0);
        expect_grant("hold_prep", 4'b0010);
        tick();
        fu_tag[1] = 5'd7; fu_data[1] = 32'h7777_7777;
        fu_tag[2] = 5'd2; fu_data[2] = 32'h2222_0000;
        drive(4'b0110, 1'b0);
        expect_grant("hold_contend", 4'b0100);
        tick();
        drive(4'b0010, 1'b0);
        expect_grant("hold_fu1", 4'b0010);
        tick();

        // Flush with FU0 valid at rr_ptr=2; FU1 packet is still on the CDB this cycle.
        fu_tag[0] = 5'd4; fu_data[0] = 32'h0F0F_0F0F;
        drive(4'b0001, 1'b1);
        expect_grant("flush_ready", 4'b0000);
        tick();
        check("flush_cdb_valid", 64'(cdb_valid), 64'd0);
        drive(4'b0001, 1'b0);
        expect_grant("post_flush_fu0", 4'b0001);
        tick();
        // rr_ptr=1 now; a flush cycle must leave it there, so FU3 beats FU0 afterwards.
        drive(4'b1111, 1'b1);
        expect_grant("flush2_ready", 4'b0000);
        tick();
        drive(4'b1001, 1'b0);
        expect_grant("flush_ptr_hold", 4'b1000);
        tick();
        drive(4'b0000, 1'b0);
        tick();

        // All four valid from reset: grants 0,1,2,3,0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < NUM_FU; i++) begin
            fu_tag[i]  = ROB_W'(16 + i);
            fu_data[i] = 32'hC0DE_0000 + 32'(i);
        end
        for (int k = 0; k < 5; k++) begin
            drive(4'b1111, 1'b0);
            expect_grant("all4_ready", 4'(1 << (k % NUM_FU)));
            tick();
            check("all4_valid", 64'(cdb_valid), 64'd1);
        end
`ifdef CDB_STATS_EN
        check("stat_grants",    64'(stat_grants),    64'd5);
        check("stat_conflicts", 64'(stat_conflicts), 64'd5);
`else
        check("stat_grants_off",    64'(stat_grants),    64'd0);
        check("stat_conflicts_off", 64'(stat_conflicts), 64'd0);
`endif

        // One more grant (FU1) leaves rr_ptr=2 with cdb_valid=1, then reset mid-stream.
        drive(4'b1111, 1'b0);
        expect_grant("pre_reset", 4'b0010);
        tick();
        reset = 1'b1;
        drive(4'b1111, 1'b0);
        check("ready_mid_reset", 64'(req_ready), 64'd0);
        tick();
        check_reset_state();
        reset = 1'b0;
        drive(4'b1111, 1'b0);
        expect_grant("ptr_after_reset", 4'b0001);
        tick();
        drive(4'b0000, 1'b0);
        tick();
        tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
